// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
// Holds the phase enum and the read-routing source enum.
package imem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_RESUME
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FETCH,
        SRC_DBG
    } grant_src_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive denied debug-read cycles.
// hit_o flags that the next contested cycle must go to the debug port.
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between CPU fetch and the debug loader.
// Also sequences the CPU through run / drain / halted / resume phases.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W            = ADDR_W_DEF,
    parameter int DATA_W            = DATA_W_DEF,
    parameter int DRAIN_CYCLES      = 2,
    parameter int RESUME_RST_CYCLES = 2,
    parameter int STARVE_LIMIT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    input  logic              dbg_halt_req_i,
    input  logic              dbg_resume_i,
    output logic              cpu_stall_o,
    output logic              cpu_reset_o,
    output logic              halted_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_MAX = (DRAIN_CYCLES > RESUME_RST_CYCLES) ? DRAIN_CYCLES : RESUME_RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_e       state_q, state_d;
    grant_src_e       src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbgRead;
    logic             starveHit;
    logic             starveInc;
    logic             starveClr;
    logic             leaveResume;

    assign dbgRead = dbg_req_i & ~dbg_we_i;

    // One shared down-counter times both the drain and the resume phases.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_gnt_o = 1'b0;
        dbg_gnt_o   = 1'b0;
        cpu_stall_o = 1'b1;
        cpu_reset_o = 1'b0;
        starveInc   = 1'b0;
        leaveResume = 1'b0;
        case (state_q)
            ST_RUN: begin
                dbg_gnt_o   = dbgRead & (~fetch_req_i | starveHit);
                fetch_gnt_o = fetch_req_i & ~dbg_gnt_o;
                cpu_stall_o = fetch_req_i & ~fetch_gnt_o;
                starveInc   = dbgRead & ~dbg_gnt_o;
                if (dbg_halt_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                dbg_gnt_o = dbgRead;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                dbg_gnt_o = dbg_req_i;
                if (dbg_resume_i && !dbg_halt_req_i) begin
                    state_d = ST_RESUME;
                    cnt_d   = CNT_W'(RESUME_RST_CYCLES);
                end
            end
            ST_RESUME: begin
                cpu_reset_o = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RUN;
                    leaveResume = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RESUME;
                cnt_d   = CNT_W'(RESUME_RST_CYCLES);
            end
        endcase
        starveClr = ~dbg_req_i | dbg_gnt_o | leaveResume;
    end

    always_comb begin
        src_d = SRC_NONE;
        if (fetch_gnt_o) begin
            src_d = SRC_FETCH;
        end else if (dbg_gnt_o && !dbg_we_i) begin
            src_d = SRC_DBG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESUME;
            cnt_q   <= CNT_W'(RESUME_RST_CYCLES);
            src_q   <= SRC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    imem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (starveInc),
        .clr_i (starveClr),
        .hit_o (starveHit)
    );

    assign halted_o       = (state_q == ST_HALTED);
    assign mem_en_o       = fetch_gnt_o | dbg_gnt_o;
    assign mem_we_o       = dbg_gnt_o & dbg_we_i;
    assign mem_addr_o     = dbg_gnt_o ? dbg_addr_i : fetch_addr_i;
    assign mem_wdata_o    = dbg_wdata_i;
    assign fetch_rvalid_o = (src_q == SRC_FETCH);
    assign dbg_rvalid_o   = (src_q == SRC_DBG);
    assign fetch_rdata_o  = mem_rdata_i;
    assign dbg_rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural 4K x 32 memory.
// Expected read data is queued at grant time and compared when rvalid appears.
module tb_imem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_halt_req;
    logic          dbg_resume;
    logic          cpu_stall;
    logic          cpu_reset;
    logic          halted;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int            checkCount = 0;
    int            failCount  = 0;
    logic [DW-1:0] fetchQ[$];
    logic [DW-1:0] dbgQ[$];
    logic [DW-1:0] memArr[4096];
    logic [DW-1:0] refMem[4096];

    imem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req_i    (fetch_req),
        .fetch_addr_i   (fetch_addr),
        .fetch_gnt_o    (fetch_gnt),
        .fetch_rvalid_o (fetch_rvalid),
        .fetch_rdata_o  (fetch_rdata),
        .dbg_req_i      (dbg_req),
        .dbg_we_i       (dbg_we),
        .dbg_addr_i     (dbg_addr),
        .dbg_wdata_i    (dbg_wdata),
        .dbg_gnt_o      (dbg_gnt),
        .dbg_rvalid_o   (dbg_rvalid),
        .dbg_rdata_o    (dbg_rdata),
        .dbg_halt_req_i (dbg_halt_req),
        .dbg_resume_i   (dbg_resume),
        .cpu_stall_o    (cpu_stall),
        .cpu_reset_o    (cpu_reset),
        .halted_o       (halted),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory macro: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memArr[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= memArr[mem_addr];
            end
        end
    end

    function automatic logic [DW-1:0] patternWord(input int a);
        return 32'hC0DE0000 ^ (32'(a) * 32'h00009E37);
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fReq, input logic [AW-1:0] fAddr,
                                 input logic dReq, input logic dWe, input logic [AW-1:0] dAddr,
                                 input logic [DW-1:0] dWdata, input logic halt, input logic resume);
        fetch_req    = fReq;
        fetch_addr   = fAddr;
        dbg_req      = dReq;
        dbg_we       = dWe;
        dbg_addr     = dAddr;
        dbg_wdata    = dWdata;
        dbg_halt_req = halt;
        dbg_resume   = resume;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard side: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (fetch_rvalid === 1'b1) begin
            if (fetchQ.size() == 0) checkOutput("fetch_rvalid_unexpected", {31'b0, fetch_rvalid}, 32'd0);
            else checkOutput("fetch_rdata", fetch_rdata, fetchQ.pop_front());
        end
        if (dbg_rvalid === 1'b1) begin
            if (dbgQ.size() == 0) checkOutput("dbg_rvalid_unexpected", {31'b0, dbg_rvalid}, 32'd0);
            else checkOutput("dbg_rdata", dbg_rdata, dbgQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] wrAddr[2];
        logic [DW-1:0] wrData[2];
        logic [AW-1:0] rdAddr[2];
        logic [AW-1:0] fAddr;
        wrAddr = '{12'h000, 12'hFFF};
        wrData = '{32'hDEADBEEF, 32'h00000013};
        rdAddr = '{12'hFFF, 12'h005};

        for (int i = 0; i < 4096; i++) begin
            memArr[i] = patternWord(i);
            refMem[i] = patternWord(i);
        end

        // Reset with both requesters active: nothing may be granted.
        rst = 1'b1;
        applyStimulus(1'b1, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        settle();
        checkOutput("rst_cpu_reset", cpu_reset, 1);
        checkOutput("rst_cpu_stall", cpu_stall, 1);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_fetch_gnt", fetch_gnt, 0);
        checkOutput("rst_dbg_gnt", dbg_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);

        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            checkOutput("resume_cpu_reset", cpu_reset, 1);
            checkOutput("resume_fetch_gnt", fetch_gnt, 0);
            nextCycle();
        end
        settle();
        checkOutput("run_cpu_reset", cpu_reset, 0);
        checkOutput("run_fetch_gnt", fetch_gnt, 1);
        checkOutput("run_mem_addr", mem_addr, 12'h000);
        fetchQ.push_back(refMem[0]);

        // Starvation: fetch always requesting, debug read pending from cycle 0.
        nextCycle();
        for (int i = 0; i <= 16; i++) begin
            fAddr = 12'(12'h100 + i);
            applyStimulus(1'b1, fAddr, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0);
            settle();
            if (i < 16) begin
                checkOutput("starve_fetch_gnt", fetch_gnt, 1);
                checkOutput("starve_dbg_gnt", dbg_gnt, 0);
                checkOutput("starve_cpu_stall", cpu_stall, 0);
                fetchQ.push_back(refMem[fAddr]);
            end else begin
                checkOutput("steal_fetch_gnt", fetch_gnt, 0);
                checkOutput("steal_dbg_gnt", dbg_gnt, 1);
                checkOutput("steal_cpu_stall", cpu_stall, 1);
                checkOutput("steal_mem_addr", mem_addr, 12'h010);
                dbgQ.push_back(refMem[12'h010]);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        settle();

        // Debug write held in RUN, then halt requested on the third cycle.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 32'h55AA1234, (i == 2), 1'b0);
            settle();
            checkOutput("run_write_blocked", dbg_gnt, 0);
            checkOutput("run_write_mem_en", mem_en, 0);
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, 12'h000, 1'b1, 1'b1, 12'h005, 32'h55AA1234, 1'b1, 1'b0);
            settle();
            checkOutput("drain_halted", halted, 0);
            checkOutput("drain_cpu_stall", cpu_stall, 1);
            checkOutput("drain_fetch_gnt", fetch_gnt, 0);
            checkOutput("drain_write_blocked", dbg_gnt, 0);
        end
        nextCycle();
        settle();
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_fetch_gnt", fetch_gnt, 0);
        checkOutput("halt_write_gnt", dbg_gnt, 1);
        checkOutput("halt_write_we", mem_we, 1);
        checkOutput("halt_write_addr", mem_addr, 12'h005);
        checkOutput("halt_write_data", mem_wdata, 32'h55AA1234);
        refMem[12'h005] = 32'h55AA1234;

        // Program load into HALTED, then read back.
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, wrAddr[i], wrData[i], 1'b1, 1'b0);
            settle();
            checkOutput("load_dbg_gnt", dbg_gnt, 1);
            checkOutput("load_mem_we", mem_we, 1);
            checkOutput("load_mem_addr", mem_addr, wrAddr[i]);
            refMem[wrAddr[i]] = wrData[i];
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, rdAddr[i], 32'h0, 1'b1, 1'b0);
            settle();
            checkOutput("readback_dbg_gnt", dbg_gnt, 1);
            checkOutput("readback_mem_we", mem_we, 0);
            checkOutput("readback_mem_addr", mem_addr, rdAddr[i]);
            dbgQ.push_back(refMem[rdAddr[i]]);
        end

        // Resume is ignored while halt is still requested.
        nextCycle();
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
        settle();
        nextCycle();
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        settle();
        checkOutput("resume_gated_halted", halted, 1);
        checkOutput("resume_gated_cpu_reset", cpu_reset, 0);
        nextCycle();
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        settle();
        checkOutput("halt_dropped_halted", halted, 1);
        nextCycle();
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
        settle();
        checkOutput("resume_pulse_halted", halted, 1);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
            settle();
            checkOutput("restart_cpu_reset", cpu_reset, 1);
            checkOutput("restart_halted", halted, 0);
            checkOutput("restart_fetch_gnt", fetch_gnt, 0);
        end
        nextCycle();
        settle();
        checkOutput("restart_run_cpu_reset", cpu_reset, 0);
        checkOutput("restart_fetch_gnt_pc0", fetch_gnt, 1);
        checkOutput("restart_fetch_addr", mem_addr, 12'h000);
        fetchQ.push_back(refMem[0]);

        // Debug read granted in the last RUN cycle, then reset in the first DRAIN cycle.
        nextCycle();
        applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 1'b0);
        settle();
        checkOutput("last_run_dbg_gnt", dbg_gnt, 1);
        dbgQ.push_back(refMem[12'h020]);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        settle();
        checkOutput("midrst_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("midrst_halted", halted, 0);
        checkOutput("midrst_cpu_reset", cpu_reset, 1);
        checkOutput("midrst_cpu_stall", cpu_stall, 1);
        checkOutput("midrst_dropped_pending", dbgQ.size(), 1);
        if (dbgQ.size() > 0) void'(dbgQ.pop_back());

        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        repeat (4) nextCycle();
        settle();
        checkOutput("fetch_queue_drained", fetchQ.size(), 0);
        checkOutput("dbg_queue_drained", dbgQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
